switch_in: RTL and testbench

- Memory-mapped input peripheral for the board's 24 DIP switches. It is the read-side counterpart of the LED output block.
- Synchronizes and debounces raw switch pins, then holds a stable 24-bit image.
- Returns 16-bit halves, or a status word, to the CPU over the memorio I/O path (chip-select, read strobe, 2-bit low address, 16-bit data).
- Tracks a sticky "switches changed" flag so software can poll cheaply.

---
 rtl/switch_in_pkg.sv | 21 ++
 rtl/switch_in_debounce_bit.sv | 52 +++++
 rtl/switch_in.sv | 75 +++++++
 tb/tb_switch_in.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/switch_in_pkg.sv
// Shared constants for the switch input peripheral: register addresses on the
// memorio path and the default debounce interval.
package switch_in_pkg;

  typedef enum logic [1:0] {
    ADDR_SW_LO   = 2'b00,
    ADDR_SW_RSV  = 2'b01,
    ADDR_SW_HI   = 2'b10,
    ADDR_SW_STAT = 2'b11
  } sw_addr_e;

  // Roughly 10 ms of stable level at a 100 MHz system clock.
  localparam int unsigned SW_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned SW_CNT_W           = 20;

  // Reading either switch half acknowledges the changed flag.
  function automatic logic clears_changed(input logic [1:0] addr);
    return (addr == ADDR_SW_LO) || (addr == ADDR_SW_HI);
  endfunction

endpackage

// File: rtl/switch_in_debounce_bit.sv
// One switch pin: two-flop synchronizer followed by a persistence counter.
// A new level is accepted only after it has been seen DEBOUNCE_CYCLES edges
// in a row; any return to the current stable level restarts the count.
module switch_in_debounce_bit
  import switch_in_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = SW_CNT_W
) (
  input  logic switch_clk,
  input  logic switchrst,
  input  logic pin,
  output logic stable,
  output logic flip
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // High on the edge where stable is about to take the synchronized level.
  assign flip = (sync_p1 != stable) && (cnt == CNT_LAST);

  // Two-flop metastability chain on the raw asynchronous pin.
  always_ff @(posedge switch_clk) begin
    if (switchrst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= pin;
      sync_p1 <= sync_p0;
    end
  end

  // Persistence counter; stable only moves after a full run of agreement.
  always_ff @(posedge switch_clk) begin
    if (switchrst) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync_p1 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= sync_p1;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/switch_in.sv
// Memory-mapped DIP switch input: per-bit debounce, sticky changed flag and
// a registered 16-bit read port on the memorio path.
module switch_in
  import switch_in_pkg::*;
#(
  parameter int unsigned SW_WIDTH        = 24,
  parameter int unsigned DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = SW_CNT_W
) (
  input  logic                switch_clk,
  input  logic                switchrst,
  input  logic                switchcs,
  input  logic                switchread,
  input  logic [1:0]          switchaddr,
  input  logic [SW_WIDTH-1:0] switch_i,
  output logic [15:0]         switchrdata
);

  logic [SW_WIDTH-1:0] stable;
  logic [SW_WIDTH-1:0] flip;
  logic [31:0]         sw_ext;
  logic                rd_sel;
  logic                changed;
  logic [15:0]         rd_word;

  for (genvar i = 0; i < SW_WIDTH; i++) begin : g_bit
    switch_in_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .switch_clk(switch_clk),
      .switchrst (switchrst),
      .pin       (switch_i[i]),
      .stable    (stable[i]),
      .flip      (flip[i])
    );
  end

  // Pins above SW_WIDTH read back as zero in the high half.
  assign sw_ext = 32'(stable);
  assign rd_sel = switchcs && switchread;

  // Select the word for this strobe from pre-edge state.
  always_comb begin
    rd_word = 16'h0000;
    case (sw_addr_e'(switchaddr))
      ADDR_SW_LO:   rd_word = sw_ext[15:0];
      ADDR_SW_HI:   rd_word = sw_ext[31:16];
      ADDR_SW_STAT: rd_word = {15'b0, changed};
      ADDR_SW_RSV:  rd_word = 16'h0000;
      default:      rd_word = 16'h0000;
    endcase
  end

  // Sticky changed flag; a toggle in the same edge as a clearing read wins.
  always_ff @(posedge switch_clk) begin
    if (switchrst) begin
      changed <= 1'b0;
    end else if (|flip) begin
      changed <= 1'b1;
    end else if (rd_sel && clears_changed(switchaddr)) begin
      changed <= 1'b0;
    end
  end

  // Read data register; holds its value when no read is selected.
  always_ff @(posedge switch_clk) begin
    if (switchrst) begin
      switchrdata <= 16'h0000;
    end else if (rd_sel) begin
      switchrdata <= rd_word;
    end
  end

endmodule

// File: tb/tb_switch_in.sv
// Bench for switch_in with a short debounce interval. A behavioural model
// tracks the pin history and accepts a level once the synchronized pin has
// disagreed with the accepted image for a full window of edges.
module tb_switch_in;

  localparam int D = 4;

  logic        switch_clk = 1'b0;
  logic        switchrst;
  logic        switchcs;
  logic        switchread;
  logic [1:0]  switchaddr;
  logic [23:0] switch_i;
  logic [15:0] switchrdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 switch_clk = ~switch_clk;

  switch_in #(
    .SW_WIDTH       (24),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .switch_clk (switch_clk),
    .switchrst  (switchrst),
    .switchcs   (switchcs),
    .switchread (switchread),
    .switchaddr (switchaddr),
    .switch_i   (switch_i),
    .switchrdata(switchrdata)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] slot(input int e);
    return 8'(e);
  endfunction

  // Reference model state
  int          n_edge   = 0;
  int          last_rst = 0;
  logic [23:0] pin_at [0:255];
  logic [23:0] s2h    [0:255];
  logic [23:0] m_stable  = '0;
  logic        m_changed = 1'b0;
  logic [15:0] exp_rd    = '0;
  logic        chk_en    = 1'b0;

  always @(posedge switch_clk) begin : model_b
    logic [23:0] s2;
    logic [23:0] nxt;
    logic        all_diff;
    n_edge++;
    pin_at[slot(n_edge)] = switch_i;
    // The pin seen two edges ago reaches the debouncer, unless a reset intervened.
    if (n_edge - 2 > last_rst) s2 = pin_at[slot(n_edge - 2)];
    else                       s2 = '0;
    s2h[slot(n_edge)] = s2;
    if (switchrst) begin
      last_rst  = n_edge;
      m_stable  = '0;
      m_changed = 1'b0;
      exp_rd    = '0;
    end else begin
      if (switchcs && switchread) begin
        case (switchaddr)
          2'b00:   exp_rd = m_stable[15:0];
          2'b10:   exp_rd = {8'h00, m_stable[23:16]};
          2'b11:   exp_rd = {15'b0, m_changed};
          default: exp_rd = 16'h0000;
        endcase
      end
      nxt = m_stable;
      if (n_edge - D + 1 > last_rst) begin
        for (int i = 0; i < 24; i++) begin
          all_diff = 1'b1;
          for (int j = 0; j < D; j++)
            if (s2h[slot(n_edge - j)][i] == m_stable[i]) all_diff = 1'b0;
          if (all_diff) nxt[i] = ~m_stable[i];
        end
      end
      if (nxt != m_stable)
        m_changed = 1'b1;
      else if (switchcs && switchread && (switchaddr == 2'b00 || switchaddr == 2'b10))
        m_changed = 1'b0;
      m_stable = nxt;
    end
  end

  always @(negedge switch_clk) begin
    if (chk_en) chk("rdata_model", switchrdata, exp_rd);
  end

  task automatic do_read(input logic [1:0] a, output logic [15:0] d);
    switchcs   = 1'b1;
    switchread = 1'b1;
    switchaddr = a;
    @(negedge switch_clk);
    d          = switchrdata;
    switchcs   = 1'b0;
    switchread = 1'b0;
  endtask

  initial begin
    logic [15:0] d;
    logic [23:0] cur;
    int          len;
    switchrst  = 1'b1;
    switchcs   = 1'b0;
    switchread = 1'b0;
    switchaddr = 2'b00;
    switch_i   = 24'hFFFFFF;
    repeat (2) @(negedge switch_clk);
    switchrst = 1'b0;
    chk_en    = 1'b1;
    do_read(2'b00, d); chk("reset_lo", d, 16'h0000);
    do_read(2'b11, d); chk("reset_stat", d, 16'h0000);
    repeat (10) @(negedge switch_clk);
    switch_i = 24'h000000;
    repeat (10) @(negedge switch_clk);
    do_read(2'b00, d); chk("settle_zero", d, 16'h0000);

    // Debounce latency
    switch_i = 24'h00A5C3;
    repeat (5) @(negedge switch_clk);
    do_read(2'b00, d); chk("lat_edge5", d, 16'h0000);
    do_read(2'b00, d); chk("lat_edge6", d, 16'hA5C3);

    // Glitch rejection
    switch_i = 24'h000000;
    repeat (10) @(negedge switch_clk);
    do_read(2'b00, d); chk("glitch_base", d, 16'h0000);
    do_read(2'b11, d); chk("glitch_base_stat", d, 16'h0000);
    switch_i = 24'h000008;
    repeat (3) @(negedge switch_clk);
    switch_i = 24'h000000;
    repeat (10) @(negedge switch_clk);
    do_read(2'b11, d); chk("glitch_stat", d, 16'h0000);
    do_read(2'b00, d); chk("glitch_lo", d, 16'h0000);

    // High half and reserved address
    switch_i = 24'h7E1234;
    repeat (10) @(negedge switch_clk);
    do_read(2'b10, d); chk("hi_half", d, 16'h007E);
    do_read(2'b00, d); chk("lo_half", d, 16'h1234);
    do_read(2'b01, d); chk("reserved", d, 16'h0000);
    do_read(2'b11, d); chk("stat_cleared", d, 16'h0000);

    // Changed flag set and cleared
    switch_i = 24'h7E1235;
    repeat (10) @(negedge switch_clk);
    do_read(2'b11, d); chk("stat_set", d, 16'h0001);
    do_read(2'b00, d); chk("lo_after_change", d, 16'h1235);
    do_read(2'b11, d); chk("stat_after_clr", d, 16'h0000);

    // Toggle coincides with the clearing read
    switch_i = 24'h7E1234;
    repeat (5) @(negedge switch_clk);
    do_read(2'b00, d); chk("coincide_lo", d, 16'h1235);
    do_read(2'b11, d); chk("coincide_stat", d, 16'h0001);

    // Hold with no chip select
    do_read(2'b10, d); chk("hold_base", d, 16'h007E);
    for (int k = 0; k < 20; k++) begin
      switchcs   = 1'b0;
      switchread = 1'($urandom_range(0, 1));
      switchaddr = 2'($urandom);
      switch_i   = 24'($urandom);
      @(negedge switch_clk);
      chk("hold", switchrdata, 16'h007E);
    end
    switchread = 1'b0;
    switch_i   = 24'h7E1234;
    repeat (10) @(negedge switch_clk);

    // Reset mid-debounce
    switch_i = 24'h00ABCD;
    repeat (3) @(negedge switch_clk);
    switchrst = 1'b1;
    @(negedge switch_clk);
    switchrst = 1'b0;
    repeat (5) @(negedge switch_clk);
    do_read(2'b00, d); chk("rst_mid_edge6", d, 16'h0000);
    do_read(2'b00, d); chk("rst_mid_edge7", d, 16'hABCD);

    // Randomized traffic checked against the model every cycle
    cur = 24'h00ABCD;
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 1) == 0) cur = 24'($urandom);
      else                           cur = cur ^ (24'h1 << $urandom_range(0, 23));
      switch_i = cur;
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++) begin
        switchrst  = ($urandom_range(0, 199) == 0);
        switchcs   = ($urandom_range(0, 2) != 0);
        switchread = 1'($urandom_range(0, 1));
        switchaddr = 2'($urandom);
        @(negedge switch_clk);
      end
    end
    switchrst  = 1'b0;
    switchcs   = 1'b0;
    switchread = 1'b0;
    repeat (2) @(negedge switch_clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
